// File: rtl/cpu15_pkg.sv
// Shared types and constants for the 15-bit CPU fetch path.
package cpu15_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 15;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0]  HLT_OPC  = 4'b1111;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        HALT,
        BREAK
    } state_t;

    function automatic logic [OPC_W-1:0] get_opc(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns P_COUNT, hides the ROM read latency, issues words over valid/ack.
// Optional breakpoint support is compiled in with FETCH_BREAKPOINT_EN.
module fetch_ctrl
    import cpu15_pkg::*;
(
    input  logic               CLK_FT,
    input  logic               RESET_N,
    input  logic               RUN,
    input  logic [INSTR_W-1:0] PROM_OUT,
    output logic [ADDR_W-1:0]  P_COUNT,
    output logic [INSTR_W-1:0] INSTR,
    output logic               INSTR_VALID,
    input  logic               INSTR_ACK,
    input  logic               JMP_EN,
    input  logic [ADDR_W-1:0]  JMP_ADDR,
`ifdef FETCH_BREAKPOINT_EN
    input  logic [ADDR_W-1:0]  BP_ADDR,
    input  logic               BP_ARM,
    input  logic               CONTINUE,
    output logic               BP_HIT,
`endif
    output logic               HALTED
);

    state_t            state;
    logic [ADDR_W-1:0] pc_step;

    // Address taken by a retired non-hlt instruction: jump target or sequential successor.
    always_comb begin
        pc_step = JMP_EN ? JMP_ADDR : P_COUNT + ADDR_W'(1);
    end

`ifdef FETCH_BREAKPOINT_EN
    logic bp_now;
    logic bp_step;

    always_comb begin
        bp_now  = BP_ARM && (P_COUNT == BP_ADDR);
        bp_step = BP_ARM && (pc_step == BP_ADDR);
    end
`endif

    always_ff @(posedge CLK_FT or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            P_COUNT     <= RESET_PC;
            INSTR       <= '0;
            INSTR_VALID <= 1'b0;
            HALTED      <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
            BP_HIT      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (RUN) begin
`ifdef FETCH_BREAKPOINT_EN
                        state  <= bp_now ? BREAK : FETCH;
                        BP_HIT <= bp_now;
`else
                        state  <= FETCH;
`endif
                    end
                end
                // ROM registers P_COUNT on this edge; data arrives during WAIT.
                FETCH: state <= WAIT;
                WAIT: begin
                    INSTR       <= PROM_OUT;
                    INSTR_VALID <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (INSTR_ACK) begin
                        INSTR_VALID <= 1'b0;
                        if (get_opc(INSTR) == HLT_OPC) begin
                            HALTED <= 1'b1;
                            state  <= HALT;
                        end else begin
                            P_COUNT <= pc_step;
                            if (RUN) begin
`ifdef FETCH_BREAKPOINT_EN
                                state  <= bp_step ? BREAK : FETCH;
                                BP_HIT <= bp_step;
`else
                                state  <= FETCH;
`endif
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                HALT: state <= HALT;
`ifdef FETCH_BREAKPOINT_EN
                // CONTINUE resumes straight into FETCH so the same breakpoint does not re-trigger.
                BREAK: begin
                    if (!RUN) begin
                        state  <= IDLE;
                        BP_HIT <= 1'b0;
                    end else if (CONTINUE) begin
                        state  <= FETCH;
                        BP_HIT <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table, directed corner sequences, randomized run vs. a latency model.
module tb_fetch_ctrl;

    logic        CLK_FT = 1'b0;
    logic        RESET_N = 1'b0;
    logic        RUN = 1'b0;
    logic [14:0] PROM_OUT = '0;
    logic [7:0]  P_COUNT;
    logic [14:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_ACK = 1'b0;
    logic        JMP_EN = 1'b0;
    logic [7:0]  JMP_ADDR = '0;
    logic        HALTED;
`ifdef FETCH_BREAKPOINT_EN
    logic [7:0]  BP_ADDR = '0;
    logic        BP_ARM = 1'b0;
    logic        CONTINUE = 1'b0;
    logic        BP_HIT;
`endif

    fetch_ctrl dut (
        .CLK_FT      (CLK_FT),
        .RESET_N     (RESET_N),
        .RUN         (RUN),
        .PROM_OUT    (PROM_OUT),
        .P_COUNT     (P_COUNT),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_ACK   (INSTR_ACK),
        .JMP_EN      (JMP_EN),
        .JMP_ADDR    (JMP_ADDR),
`ifdef FETCH_BREAKPOINT_EN
        .BP_ADDR     (BP_ADDR),
        .BP_ARM      (BP_ARM),
        .CONTINUE    (CONTINUE),
        .BP_HIT      (BP_HIT),
`endif
        .HALTED      (HALTED)
    );

    initial forever #5 CLK_FT = ~CLK_FT;

    // Program ROM with one-cycle registered read.
    logic [14:0] rom [256];
    always @(posedge CLK_FT) PROM_OUT <= rom[P_COUNT];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_FT);
        #1;
    endtask

    task automatic drive(input bit run, input bit ack, input bit jen, input logic [7:0] ja);
        RUN = run; INSTR_ACK = ack; JMP_EN = jen; JMP_ADDR = ja;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 8'h00);
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !INSTR_VALID; i++) tick();
        check("wait_valid", INSTR_VALID, 1);
    endtask

    // Precondition: an instruction is being presented. Jumps to addr and waits for its word.
    task automatic go_issue_at(input logic [7:0] addr);
        drive(1, 1, 1, addr);
        tick();
        drive(1, 0, 0, 8'h00);
        wait_valid(8);
        check("issue_pc", P_COUNT, addr);
        check("issue_instr", INSTR, rom[addr]);
    endtask

    typedef struct {
        bit          run;
        bit          ack;
        bit          jen;
        logic [7:0]  jaddr;
        logic [7:0]  pc;
        bit          vld;
        logic [14:0] instr;
    } vec_t;

    vec_t tbl [16];

    // Abstract model: a fetch request becomes a presented word two edges later.
    logic [7:0]  m_pc;
    logic [14:0] m_instr;
    bit          m_valid, m_halt;
    int          m_cd;

    task automatic model_reset();
        m_pc = 8'h00; m_instr = '0; m_valid = 0; m_halt = 0; m_cd = 0;
    endtask

    task automatic model_edge(input bit run, input bit ack, input bit jen, input logic [7:0] ja);
        if (m_halt) begin
        end else if (m_valid) begin
            if (ack) begin
                m_valid = 0;
                if (m_instr[14:11] == 4'hF) m_halt = 1;
                else begin
                    m_pc = jen ? ja : m_pc + 8'd1;
                    if (run) m_cd = 2;
                end
            end
        end else if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
                m_valid = 1;
                m_instr = rom[m_pc];
            end
        end else if (run) begin
            m_cd = 2;
        end
    endtask

    initial begin
        logic [14:0] w;
        int          halt_cnt;

        for (int i = 0; i < 256; i++) begin
            w = 15'($urandom);
            if (w[14:11] == 4'hF) w[14] = 1'b0;
            rom[i] = w;
        end
        rom[8'h00] = 15'h0001;
        rom[8'h01] = 15'h1234;
        rom[8'h20] = 15'h0ABC;
        rom[8'h21] = 15'h2222;
        rom[8'h14] = 15'b111100000000000;

        tbl[0]  = '{1, 1, 0, 8'h00, 8'h00, 0, 15'h0000};
        tbl[1]  = '{1, 1, 0, 8'h00, 8'h00, 0, 15'h0000};
        tbl[2]  = '{1, 1, 0, 8'h00, 8'h00, 1, 15'h0001};
        tbl[3]  = '{1, 1, 0, 8'h00, 8'h01, 0, 15'h0001};
        tbl[4]  = '{1, 1, 0, 8'h00, 8'h01, 0, 15'h0001};
        tbl[5]  = '{1, 1, 0, 8'h00, 8'h01, 1, 15'h1234};
        tbl[6]  = '{1, 1, 1, 8'h20, 8'h20, 0, 15'h1234};
        tbl[7]  = '{1, 0, 0, 8'h00, 8'h20, 0, 15'h1234};
        tbl[8]  = '{1, 0, 0, 8'h00, 8'h20, 1, 15'h0ABC};
        tbl[9]  = '{1, 0, 0, 8'h00, 8'h20, 1, 15'h0ABC};
        tbl[10] = '{0, 1, 0, 8'h00, 8'h21, 0, 15'h0ABC};
        tbl[11] = '{0, 1, 0, 8'h00, 8'h21, 0, 15'h0ABC};
        tbl[12] = '{0, 0, 1, 8'h77, 8'h21, 0, 15'h0ABC};
        tbl[13] = '{1, 0, 0, 8'h00, 8'h21, 0, 15'h0ABC};
        tbl[14] = '{1, 0, 0, 8'h00, 8'h21, 0, 15'h0ABC};
        tbl[15] = '{1, 0, 0, 8'h00, 8'h21, 1, 15'h2222};

        tick();
        check("reset_pc", P_COUNT, 8'h00);
        check("reset_valid", INSTR_VALID, 0);
        check("reset_instr", INSTR, 15'h0);
        check("reset_halted", HALTED, 0);
        RESET_N = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].run, tbl[i].ack, tbl[i].jen, tbl[i].jaddr);
            tick();
            check($sformatf("tbl%0d_pc", i), P_COUNT, tbl[i].pc);
            check($sformatf("tbl%0d_valid", i), INSTR_VALID, tbl[i].vld);
            check($sformatf("tbl%0d_instr", i), INSTR, tbl[i].instr);
            check($sformatf("tbl%0d_halted", i), HALTED, 0);
        end

        // Stall: ACK low for five cycles at address 3.
        go_issue_at(8'h03);
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", INSTR_VALID, 1);
            check("stall_instr", INSTR, rom[8'h03]);
            check("stall_pc", P_COUNT, 8'h03);
        end
        drive(1, 1, 0, 8'h00);
        tick();
        check("stall_adv_pc", P_COUNT, 8'h04);
        check("stall_adv_valid", INSTR_VALID, 0);

        // Jump 0x13 -> 0x08 drives no intermediate address.
        wait_valid(8);
        go_issue_at(8'h13);
        drive(1, 1, 1, 8'h08);
        tick();
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check("jmp_pc", P_COUNT, 8'h08);
            if (i < 2) tick();
        end
        check("jmp_valid", INSTR_VALID, 1);
        check("jmp_instr", INSTR, rom[8'h08]);

        // Self-loop jump refetches the same address.
        drive(1, 1, 1, 8'h08);
        tick();
        drive(1, 0, 0, 8'h00);
        wait_valid(8);
        check("self_pc", P_COUNT, 8'h08);

        // hlt at 0x14 with JMP_EN asserted at the retiring ACK.
        go_issue_at(8'h14);
        drive(1, 1, 1, 8'h30);
        tick();
        check("hlt_halted", HALTED, 1);
        check("hlt_pc", P_COUNT, 8'h14);
        check("hlt_valid", INSTR_VALID, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("halt_valid", INSTR_VALID, 0);
            check("halt_pc", P_COUNT, 8'h14);
        end
        #2 RESET_N = 1'b0;
        #1;
        check("halt_rst_halted", HALTED, 0);
        check("halt_rst_pc", P_COUNT, 8'h00);
        tick();
        RESET_N = 1'b1;

        // Wrap from 0xFF.
        drive(1, 0, 0, 8'h00);
        wait_valid(8);
        go_issue_at(8'hFF);
        drive(1, 1, 0, 8'h00);
        tick();
        check("wrap_pc", P_COUNT, 8'h00);
        drive(1, 0, 0, 8'h00);
        wait_valid(8);
        check("wrap_instr", INSTR, rom[8'h00]);

        // Async reset during WAIT drops the in-flight word immediately.
        go_issue_at(8'h40);
        drive(1, 1, 0, 8'h00);
        tick();
        drive(1, 0, 0, 8'h00);
        tick();
        #2 RESET_N = 1'b0;
        #1;
        check("wait_rst_valid", INSTR_VALID, 0);
        check("wait_rst_pc", P_COUNT, 8'h00);
        check("wait_rst_instr", INSTR, 15'h0);
        drive(0, 0, 0, 8'h00);
        tick();
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_valid", INSTR_VALID, 0);
            check("post_rst_pc", P_COUNT, 8'h00);
        end

`ifdef FETCH_BREAKPOINT_EN
        do_reset();
        BP_ADDR = 8'h05;
        BP_ARM = 1'b1;
        drive(1, 0, 0, 8'h00);
        wait_valid(8);
        drive(1, 1, 1, 8'h05);
        tick();
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            check("bp_hit", BP_HIT, 1);
            check("bp_valid", INSTR_VALID, 0);
            check("bp_pc", P_COUNT, 8'h05);
            tick();
        end
        CONTINUE = 1'b1;
        tick();
        CONTINUE = 1'b0;
        check("bp_cont_hit", BP_HIT, 0);
        wait_valid(8);
        check("bp_cont_instr", INSTR, rom[8'h05]);
        drive(1, 1, 1, 8'h05);
        tick();
        check("bp_rehit", BP_HIT, 1);
        drive(0, 0, 0, 8'h00);
        tick();
        check("bp_run0_hit", BP_HIT, 0);
        tick();
        check("bp_run0_valid", INSTR_VALID, 0);
        BP_ARM = 1'b0;
`endif

        // Randomized traffic against the latency model.
        do_reset();
        model_reset();
        halt_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            bit r, a, j;
            logic [7:0] ja;
            r  = ($urandom % 4) != 0;
            a  = ($urandom % 2) == 0;
            j  = ($urandom % 4) == 0;
            ja = 8'($urandom);
            drive(r, a, j, ja);
            model_edge(r, a, j, ja);
            tick();
            check("rnd_pc", P_COUNT, m_pc);
            check("rnd_valid", INSTR_VALID, m_valid);
            check("rnd_instr", INSTR, m_instr);
            check("rnd_halted", HALTED, m_halt);
            if (m_halt) halt_cnt++;
            if (halt_cnt > 4) begin
                do_reset();
                model_reset();
                halt_cnt = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
